// File: rtl/ac_pkg.sv
// Shared constants for the multi-zone air-conditioner controller:
// mode encoding, AUTO level thresholds/offsets and FAST/ECO settings.
package ac_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_AUTO = 2'b01;
  localparam logic [1:0] MODE_FAST = 2'b10;
  localparam logic [1:0] MODE_ECO  = 2'b11;

  // |temp - setpoint| needed to reach AUTO level 1, 2, 3
  localparam int unsigned AUTO_THR_1 = 3;
  localparam int unsigned AUTO_THR_2 = 5;
  localparam int unsigned AUTO_THR_3 = 7;

  // outlet offset below setpoint at AUTO level 1, 2, 3
  localparam int unsigned AUTO_OFF_1 = 1;
  localparam int unsigned AUTO_OFF_2 = 3;
  localparam int unsigned AUTO_OFF_3 = 5;

  localparam logic [2:0]  FAST_SPEED  = 3'd4;
  localparam int unsigned FAST_OFFSET = 5;
  localparam logic [2:0]  ECO_SPEED   = 3'd2;
  localparam int unsigned ECO_OFFSET  = 2;

  // Button sequence OFF -> AUTO -> FAST -> ECO -> OFF
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      MODE_OFF:  return MODE_AUTO;
      MODE_AUTO: return MODE_FAST;
      MODE_FAST: return MODE_ECO;
      default:   return MODE_OFF;
    endcase
  endfunction

  // Entry threshold of an AUTO level (level 0 has none)
  function automatic int unsigned auto_thr(input logic [1:0] lvl);
    case (lvl)
      2'd1:    return AUTO_THR_1;
      2'd2:    return AUTO_THR_2;
      2'd3:    return AUTO_THR_3;
      default: return 0;
    endcase
  endfunction

  // Outlet offset of an AUTO level
  function automatic int unsigned auto_offset(input logic [1:0] lvl);
    case (lvl)
      2'd1:    return AUTO_OFF_1;
      2'd2:    return AUTO_OFF_2;
      2'd3:    return AUTO_OFF_3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/ac_zone_channel.sv
// One zone: registers |temp - setpoint|, tracks the AUTO level with
// hysteresis and produces the requested (ungated) speed and outlet target.
// Outputs are combinational from the level's next state so the top-level
// output register lines up with the level register.
module ac_zone_channel
  import ac_pkg::*;
#(
  parameter int TEMP_W = 7,
  parameter int HYST   = 1
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic [TEMP_W-1:0] temp_i,
  input  logic [TEMP_W-1:0] setpoint_i,
  input  logic              enable_i,
  input  logic [1:0]        mode_i,
  output logic [2:0]        speed_o,
  output logic [TEMP_W-1:0] heat_o
);

  localparam logic [31:0] HYST_U = 32'(HYST);

  logic [TEMP_W-1:0] diff_d, diff_q, sp_q;
  logic              en_q;
  logic [1:0]        lvl_d, lvl_q, up_lvl;
  logic [31:0]       diff_ext, sp_ext, offset;
  logic [2:0]        speed_d;
  logic              heat_zero;

  // Absolute difference without wrap-around
  always_comb diff_d = (temp_i >= setpoint_i) ? temp_i - setpoint_i : setpoint_i - temp_i;

  // Stage 1: diff, setpoint and enable captured together
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      diff_q <= '0;
      sp_q   <= '0;
      en_q   <= 1'b0;
    end else begin
      diff_q <= diff_d;
      sp_q   <= setpoint_i;
      en_q   <= enable_i;
    end
  end

  // Level update: jump up at once, step down one level below threshold-HYST
  always_comb begin
    diff_ext = 32'(diff_q);
    up_lvl   = 2'd0;
    if (diff_ext >= AUTO_THR_3)      up_lvl = 2'd3;
    else if (diff_ext >= AUTO_THR_2) up_lvl = 2'd2;
    else if (diff_ext >= AUTO_THR_1) up_lvl = 2'd1;
    lvl_d = lvl_q;
    if (!en_q || mode_i == MODE_OFF) begin
      lvl_d = 2'd0;
    end else if (up_lvl > lvl_q) begin
      lvl_d = up_lvl;
    end else if (lvl_q != 2'd0 && (diff_ext + HYST_U) < auto_thr(lvl_q)) begin
      lvl_d = lvl_q - 2'd1;
    end
  end

  // Stage 2: AUTO level register (also tracked outside AUTO unless OFF)
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) lvl_q <= 2'd0;
    else         lvl_q <= lvl_d;
  end

  // Requested speed and saturating outlet target for the current mode
  always_comb begin
    speed_d   = 3'd0;
    offset    = 32'd0;
    heat_zero = 1'b1;
    case (mode_i)
      MODE_AUTO: begin
        speed_d   = {1'b0, lvl_d};
        offset    = auto_offset(lvl_d);
        heat_zero = (lvl_d == 2'd0);
      end
      MODE_FAST: begin
        speed_d   = FAST_SPEED;
        offset    = FAST_OFFSET;
        heat_zero = 1'b0;
      end
      MODE_ECO: begin
        speed_d   = ECO_SPEED;
        offset    = ECO_OFFSET;
        heat_zero = 1'b0;
      end
      default: ;
    endcase
    if (!en_q) begin
      speed_d   = 3'd0;
      heat_zero = 1'b1;
    end
    sp_ext  = 32'(sp_q);
    speed_o = speed_d;
    if (heat_zero || sp_ext <= offset) heat_o = '0;
    else                               heat_o = TEMP_W'(sp_ext - offset);
  end

endmodule

// File: rtl/ac_zone_controller.sv
// Multi-zone AC controller: mode FSM, per-zone channels, shared compressor
// with minimum-off lockout, and output registers gated by the compressor.
module ac_zone_controller
  import ac_pkg::*;
#(
  parameter int N_ZONES     = 4,
  parameter int TEMP_W      = 7,
  parameter int HYST        = 1,
  parameter int MIN_OFF_CYC = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      button_mode,
  input  logic [TEMP_W-1:0]         setpoint,
  input  logic [N_ZONES*TEMP_W-1:0] zone_temp,
  input  logic [N_ZONES-1:0]        zone_enable,
  output logic [1:0]                mode,
  output logic [N_ZONES*3-1:0]      fan_speed,
  output logic [N_ZONES*TEMP_W-1:0] fan_heat,
  output logic                      compressor_on
);

  localparam int LOCK_W = $clog2(MIN_OFF_CYC + 1);
  localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(MIN_OFF_CYC);

  logic                      btn_q;
  logic [1:0]                mode_d, mode_q;
  logic [N_ZONES*3-1:0]      req_speed, fan_speed_q;
  logic [N_ZONES*TEMP_W-1:0] req_heat, fan_heat_q;
  logic [N_ZONES-1:0]        zone_req;
  logic                      request;
  logic                      comp_d, comp_q;
  logic [LOCK_W-1:0]         lock_d, lock_q;

  // Advance mode once per rising edge of the button level
  always_comb mode_d = (button_mode && !btn_q) ? next_mode(mode_q) : mode_q;

  // Button history and mode register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q  <= 1'b0;
      mode_q <= MODE_OFF;
    end else begin
      btn_q  <= button_mode;
      mode_q <= mode_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_ZONES; gi++) begin : g_zone
      ac_zone_channel #(
        .TEMP_W (TEMP_W),
        .HYST   (HYST)
      ) u_channel (
        .clk        (clk),
        .rst_ni     (reset),
        .temp_i     (zone_temp[gi*TEMP_W +: TEMP_W]),
        .setpoint_i (setpoint),
        .enable_i   (zone_enable[gi]),
        .mode_i     (mode_q),
        .speed_o    (req_speed[gi*3 +: 3]),
        .heat_o     (req_heat[gi*TEMP_W +: TEMP_W])
      );
      assign zone_req[gi] = |req_speed[gi*3 +: 3];
    end
  endgenerate

  assign request = |zone_req;

  // Compressor: off on request drop with lockout reload; on only once lockout is 0
  always_comb begin
    comp_d = comp_q;
    lock_d = lock_q;
    if (comp_q) begin
      if (!request) begin
        comp_d = 1'b0;
        lock_d = LOCK_INIT;
      end
    end else if (lock_q != '0) begin
      lock_d = lock_q - LOCK_W'(1);
    end else if (request) begin
      comp_d = 1'b1;
    end
  end

  // Compressor state, lockout counter and fan outputs (zero while compressor off)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      comp_q      <= 1'b0;
      lock_q      <= '0;
      fan_speed_q <= '0;
      fan_heat_q  <= '0;
    end else begin
      comp_q      <= comp_d;
      lock_q      <= lock_d;
      fan_speed_q <= comp_q ? req_speed : '0;
      fan_heat_q  <= comp_q ? req_heat : '0;
    end
  end

  assign mode          = mode_q;
  assign fan_speed     = fan_speed_q;
  assign fan_heat      = fan_heat_q;
  assign compressor_on = comp_q;

endmodule

// File: tb/tb_ac_zone_controller.sv
// Directed scenarios plus randomized stimulus, every cycle compared against
// a behavioural model of the controller's rules.
module tb_ac_zone_controller;

  localparam int NZ   = 4;
  localparam int TW   = 7;
  localparam int HYST = 1;
  localparam int MOC  = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             button_mode;
  logic [TW-1:0]    setpoint;
  logic [NZ*TW-1:0] zone_temp;
  logic [NZ-1:0]    zone_enable;
  logic [1:0]       mode;
  logic [NZ*3-1:0]  fan_speed;
  logic [NZ*TW-1:0] fan_heat;
  logic             compressor_on;

  int t_v [NZ];
  int checks_cnt = 0;
  int errors_cnt = 0;

  // model state
  int m_mode, m_lock, m_sp;
  bit m_btn, m_comp;
  int m_lvl [NZ];
  int m_diff [NZ];
  bit m_en [NZ];
  int e_speed [NZ];
  int e_heat [NZ];

  int thr_tab [4] = '{0, 3, 5, 7};
  int off_tab [4] = '{0, 1, 3, 5};

  ac_zone_controller #(
    .N_ZONES(NZ), .TEMP_W(TW), .HYST(HYST), .MIN_OFF_CYC(MOC)
  ) dut (
    .clk(clk), .reset(reset_n), .button_mode(button_mode), .setpoint(setpoint),
    .zone_temp(zone_temp), .zone_enable(zone_enable), .mode(mode),
    .fan_speed(fan_speed), .fan_heat(fan_heat), .compressor_on(compressor_on)
  );

  always #5 clk = ~clk;

  always_comb begin
    zone_temp = '0;
    for (int z = 0; z < NZ; z++) zone_temp[z*TW +: TW] = TW'(t_v[z]);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks_cnt++;
    if (got != exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_lock = 0; m_sp = 0; m_btn = 0; m_comp = 0;
    for (int z = 0; z < NZ; z++) begin
      m_lvl[z] = 0; m_diff[z] = 0; m_en[z] = 0; e_speed[z] = 0; e_heat[z] = 0;
    end
  endfunction

  function automatic int sat_sub(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction

  // One clock edge of the reference behaviour
  function automatic void model_clock();
    bit any_req;
    int s, h, target, d;
    if (!reset_n) begin
      model_reset();
      return;
    end
    any_req = 0;
    for (int z = 0; z < NZ; z++) begin
      if (!m_en[z] || m_mode == 0) begin
        m_lvl[z] = 0;
      end else begin
        target = 0;
        for (int l = 1; l <= 3; l++) if (m_diff[z] >= thr_tab[l]) target = l;
        if (target > m_lvl[z]) m_lvl[z] = target;
        else if (m_lvl[z] > 0 && m_diff[z] < thr_tab[m_lvl[z]] - HYST) m_lvl[z]--;
      end
      s = 0; h = 0;
      if (m_en[z]) begin
        if (m_mode == 1) begin
          s = m_lvl[z];
          h = (m_lvl[z] == 0) ? 0 : sat_sub(m_sp, off_tab[m_lvl[z]]);
        end else if (m_mode == 2) begin
          s = 4; h = sat_sub(m_sp, 5);
        end else if (m_mode == 3) begin
          s = 2; h = sat_sub(m_sp, 2);
        end
      end
      if (s > 0) any_req = 1;
      e_speed[z] = m_comp ? s : 0;
      e_heat[z]  = m_comp ? h : 0;
    end
    if (m_comp) begin
      if (!any_req) begin m_comp = 0; m_lock = MOC; end
    end else if (m_lock > 0) m_lock--;
    else if (any_req) m_comp = 1;
    if (button_mode && !m_btn) m_mode = (m_mode + 1) % 4;
    m_btn = button_mode;
    for (int z = 0; z < NZ; z++) begin
      d = t_v[z] - int'(setpoint);
      m_diff[z] = (d < 0) ? -d : d;
      m_en[z] = zone_enable[z];
    end
    m_sp = int'(setpoint);
  endfunction

  task automatic compare_all();
    check_eq("mode", int'(mode), m_mode);
    check_eq("compressor", int'(compressor_on), int'(m_comp));
    for (int z = 0; z < NZ; z++) begin
      check_eq($sformatf("speed%0d", z), int'(fan_speed[z*3 +: 3]), e_speed[z]);
      check_eq($sformatf("heat%0d", z), int'(fan_heat[z*TW +: TW]), e_heat[z]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  task automatic pulse();
    button_mode = 1'b1; tick();
    button_mode = 1'b0; tick(); tick();
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_now_mode", int'(mode), 0);
    check_eq("rst_now_comp", int'(compressor_on), 0);
    check_eq("rst_now_speed", int'(fan_speed), 0);
    check_eq("rst_now_heat", int'(fan_heat), 0);
    tick(); tick();
    #2 reset_n = 1'b1;
    tick();
  endtask

  function automatic int clampt(input int v);
    return (v < 0) ? 0 : (v > 127) ? 127 : v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode_seq [4] = '{1, 2, 3, 0};
    int zi;
    reset_n = 1'b0; button_mode = 1'b0; setpoint = 22; zone_enable = 4'b0001;
    for (int z = 0; z < NZ; z++) t_v[z] = 22;
    model_reset();
    tick(); tick();
    #2 reset_n = 1'b1;
    check_eq("rst_mode", int'(mode), 0);
    check_eq("rst_comp", int'(compressor_on), 0);
    check_eq("rst_speed", int'(fan_speed), 0);
    tick();

    // mode stepping and held button
    for (int i = 0; i < 4; i++) begin
      pulse();
      check_eq("mode_step", int'(mode), mode_seq[i]);
    end
    button_mode = 1'b1;
    repeat (10) tick();
    button_mode = 1'b0;
    tick(); tick();
    check_eq("mode_held", int'(mode), 1);
    repeat (20) tick();

    // AUTO levels
    t_v[0] = 26; tick(); tick();
    check_eq("comp_first", int'(compressor_on), 1);
    check_eq("fan_after_comp", int'(fan_speed[2:0]), 0);
    tick();
    check_eq("auto_d4_speed", int'(fan_speed[2:0]), 1);
    check_eq("auto_d4_heat", int'(fan_heat[TW-1:0]), 21);
    t_v[0] = 30; repeat (3) tick();
    check_eq("auto_d8_speed", int'(fan_speed[2:0]), 3);
    check_eq("auto_d8_heat", int'(fan_heat[TW-1:0]), 17);
    t_v[0] = 40; repeat (3) tick();
    check_eq("auto_sat_speed", int'(fan_speed[2:0]), 3);

    // hysteresis on the way down
    t_v[0] = 27; repeat (3) tick();
    check_eq("hyst_d5", int'(fan_speed[2:0]), 2);
    t_v[0] = 26; repeat (3) tick();
    check_eq("hyst_d4", int'(fan_speed[2:0]), 2);
    t_v[0] = 25; repeat (3) tick();
    check_eq("hyst_d3", int'(fan_speed[2:0]), 1);
    t_v[0] = 24; repeat (3) tick();
    check_eq("hyst_d2", int'(fan_speed[2:0]), 1);
    t_v[0] = 23; tick(); tick();
    check_eq("drop_comp", int'(compressor_on), 0);
    check_eq("drop_speed", int'(fan_speed[2:0]), 0);
    tick(); tick();

    // lockout: request returns while counter still running
    t_v[0] = 26;
    for (int k = 0; k < 14; k++) begin
      tick();
      check_eq("lock_comp", int'(compressor_on), 0);
      check_eq("lock_fan", int'(fan_speed[2:0]), 0);
    end
    tick();
    check_eq("lock_release", int'(compressor_on), 1);
    tick();
    check_eq("lock_fan_on", int'(fan_speed[2:0]), 1);

    // FAST with saturated heat and per-zone enable
    setpoint = 3; zone_enable = 4'b0101;
    for (int z = 0; z < NZ; z++) t_v[z] = 3;
    pulse(); tick(); tick();
    check_eq("fast_mode", int'(mode), 2);
    check_eq("fast_speed0", int'(fan_speed[2:0]), 4);
    check_eq("fast_heat0", int'(fan_heat[TW-1:0]), 0);
    check_eq("fast_speed1", int'(fan_speed[5:3]), 0);
    check_eq("fast_speed2", int'(fan_speed[8:6]), 4);
    check_eq("fast_speed3", int'(fan_speed[11:9]), 0);
    check_eq("fast_comp", int'(compressor_on), 1);

    // asynchronous reset during FAST
    async_reset();
    check_eq("post_rst_mode", int'(mode), 0);

    // randomized operation
    setpoint = 22; zone_enable = 4'b1111;
    for (int z = 0; z < NZ; z++) t_v[z] = 22;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 39) == 0) button_mode = ~button_mode;
      for (int z = 0; z < NZ; z++) begin
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) t_v[z] = clampt(int'(setpoint) + int'($urandom_range(0, 30)) - 15);
        else if (r < 3) t_v[z] = clampt(t_v[z] + 1);
        else if (r < 5) t_v[z] = clampt(t_v[z] - 1);
      end
      if ($urandom_range(0, 99) == 0) setpoint = TW'($urandom_range(0, 40));
      if ($urandom_range(0, 59) == 0) begin
        zi = $urandom_range(0, NZ - 1);
        zone_enable[zi] = ~zone_enable[zi];
      end
      if ($urandom_range(0, 799) == 0) async_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
